// File: rtl/uart_pkg.sv
// Shared UART definitions: common character width and the receive-controller state encoding.
package uart_pkg;

    localparam int DEFAULT_N_DATA_BITS = 8;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        LISTEN = 2'd1,
        ACTIVE = 2'd2
    } rx_ctrl_state_t;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Host-side valid/ready stream out of the receive controller, plus the buffer occupancy.
interface uart_rx_ctrl_if #(
    parameter int N_DATA_BITS = uart_pkg::DEFAULT_N_DATA_BITS,
    parameter int FIFO_DEPTH  = 8
);
    localparam int LEVEL_W = $clog2(FIFO_DEPTH + 1);

    logic [N_DATA_BITS-1:0] data;
    logic                   valid;
    logic                   ready;
    logic [LEVEL_W-1:0]     level;

    modport master (output data, output valid, output level, input ready);
    modport slave  (input data, input valid, input level, output ready);

endinterface

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO; the head word is always visible on o_head.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int LEVEL_W = $clog2(DEPTH + 1)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_push,
    input  logic [WIDTH-1:0]   i_push_data,
    input  logic               i_pop,
    output logic [WIDTH-1:0]   o_head,
    output logic               o_full,
    output logic               o_empty,
    output logic [LEVEL_W-1:0] o_level
);

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LEVEL_W-1:0] level;
    logic [LEVEL_W-1:0] level_nxt;
    logic               do_push;
    logic               do_pop;

    // A push into a full buffer is still taken when the head leaves in the same cycle.
    assign do_pop  = i_pop && !o_empty;
    assign do_push = i_push && (!o_full || do_pop);

    always_comb begin
        level_nxt = level;
        case ({do_push, do_pop})
            2'b10:   level_nxt = level + LEVEL_W'(1);
            2'b01:   level_nxt = level - LEVEL_W'(1);
            default: level_nxt = level;
        endcase
    end

    // NOTE: the storage array has no reset; occupancy and pointers alone define which words are live.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= i_push_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            o_empty <= 1'b1;
            o_full  <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level   <= level_nxt;
            o_empty <= (level_nxt == '0);
            o_full  <= (level_nxt == LEVEL_W'(DEPTH));
        end
    end

    assign o_head  = mem[rd_ptr];
    assign o_level = level;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive controller: arms uart_rx, buffers characters for the host, flags end-of-message
// by line idle time and records dropped characters.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int N_DATA_BITS = DEFAULT_N_DATA_BITS,
    parameter int FIFO_DEPTH  = 8,
    parameter int IDLE_CYCLES = 1040
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_enable,
    input  logic                   i_clear_err,
    output logic                   o_rx_en,
    input  logic [N_DATA_BITS-1:0] i_rx_data,
    input  logic                   i_rx_valid,
    uart_rx_ctrl_if.master         host,
    output logic                   o_idle,
    output logic                   o_overflow
);

    localparam int CNT_W = $clog2(IDLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(IDLE_CYCLES - 2);

    rx_ctrl_state_t   state;
    rx_ctrl_state_t   state_nxt;
    logic [CNT_W-1:0] idle_cnt;
    logic             pop_fire;
    logic             fifo_full;
    logic             fifo_empty;
    logic             drop;

    assign pop_fire   = host.valid && host.ready;
    assign drop       = i_rx_valid && fifo_full && !pop_fire;
    assign host.valid = !fifo_empty;

    uart_sync_fifo #(
        .WIDTH (N_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_push      (i_rx_valid),
        .i_push_data (i_rx_data),
        .i_pop       (host.ready),
        .o_head      (host.data),
        .o_full      (fifo_full),
        .o_empty     (fifo_empty),
        .o_level     (host.level)
    );

    // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            OFF:     state_nxt = LISTEN;
            LISTEN:  if (i_rx_valid) state_nxt = ACTIVE;
            ACTIVE:  if (!i_rx_valid && idle_cnt == CNT_LAST) state_nxt = LISTEN;
            default: state_nxt = OFF;
        endcase
        if (!i_enable) begin
            state_nxt = OFF;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= OFF;
            idle_cnt   <= '0;
            o_rx_en    <= 1'b0;
            o_idle     <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            state   <= state_nxt;
            o_rx_en <= (state_nxt != OFF);

            if (state == ACTIVE && !i_rx_valid && idle_cnt != CNT_LAST) begin
                idle_cnt <= idle_cnt + CNT_W'(1);
            end else begin
                idle_cnt <= '0;
            end

            // Raised one cycle early so the registered pulse lines up with the count reaching its end.
            o_idle <= i_enable && (state == ACTIVE) && !i_rx_valid && (idle_cnt == CNT_PRE);

            if (drop) begin
                o_overflow <= 1'b1;
            end else if (i_clear_err) begin
                o_overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: hand sequences for arming, idle timing, disable and reset,
// a vector table for fill/overflow/drain, and a scoreboard checking every byte the host accepts.
module tb_uart_rx_ctrl;
    import uart_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int IDLE  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          clear_err;
    logic          rx_en;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          idle;
    logic          overflow;

    uart_rx_ctrl_if #(.N_DATA_BITS(DW), .FIFO_DEPTH(DEPTH)) host ();

    uart_rx_ctrl #(
        .N_DATA_BITS (DW),
        .FIFO_DEPTH  (DEPTH),
        .IDLE_CYCLES (IDLE)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_enable    (enable),
        .i_clear_err (clear_err),
        .o_rx_en     (rx_en),
        .i_rx_data   (rx_data),
        .i_rx_valid  (rx_valid),
        .host        (host),
        .o_idle      (idle),
        .o_overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rx_valid;
        logic [DW-1:0] rx_data;
        logic          ready;
        logic          clear_err;
        logic [3:0]    exp_level;
        logic          exp_valid;
        logic          exp_overflow;
    } vec_t;

    int            vectors     = 0;
    int            miscompares = 0;
    logic [DW-1:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Host side: every accepted head word must match the oldest byte the bench expects.
    always @(negedge clk) begin : monitor
        logic [DW-1:0] exp_byte;
        if (!rst && host.valid && host.ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL pop_unexpected: got 0x%0h, required no data", host.data);
            end else begin
                exp_byte = exp_q.pop_front();
                check("pop_data", host.data, exp_byte);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs [19];
        int   model_level;
        int   idle_seen;
        bit   pop;

        rst        = 1'b1;
        enable     = 1'b0;
        clear_err  = 1'b0;
        rx_valid   = 1'b0;
        rx_data    = '0;
        host.ready = 1'b0;
        repeat (3) step();

        // Reset values, then arm at cycle 5.
        rst = 1'b0;
        check("rst_rx_en", rx_en, 0);
        check("rst_valid", host.valid, 0);
        check("rst_level", host.level, 0);
        check("rst_idle", idle, 0);
        check("rst_overflow", overflow, 0);
        check("rst_state", dut.state, OFF);
        for (int c = 0; c < 5; c++) step();
        check("pre_arm_rx_en", rx_en, 0);
        enable = 1'b1;
        step();
        check("arm_rx_en", rx_en, 1);
        check("arm_valid", host.valid, 0);
        check("arm_level", host.level, 0);
        check("arm_idle", idle, 0);
        check("arm_overflow", overflow, 0);
        check("arm_state", dut.state, LISTEN);

        // Two bytes 20 cycles apart; the idle pulse lands 16 cycles after each.
        host.ready = 1'b1;
        rx_valid   = 1'b1;
        rx_data    = 8'hA5;
        exp_q.push_back(8'hA5);
        step();
        rx_valid = 1'b0;
        check("a5_valid", host.valid, 1);
        check("a5_data", host.data, 8'hA5);
        check("a5_state", dut.state, ACTIVE);
        for (int k = 1; k < 20; k++) begin
            check($sformatf("idle_a5_k%0d", k), idle, (k == IDLE));
            step();
        end
        rx_valid = 1'b1;
        rx_data  = 8'h3C;
        exp_q.push_back(8'h3C);
        step();
        rx_valid = 1'b0;
        check("3c_valid", host.valid, 1);
        check("3c_data", host.data, 8'h3C);
        idle_seen = 0;
        for (int k = 1; k <= 20; k++) begin
            check($sformatf("idle_3c_k%0d", k), idle, (k == IDLE));
            if (idle) idle_seen++;
            step();
        end
        check("3c_idle_count", idle_seen, 1);
        check("3c_state_listen", dut.state, LISTEN);
        check("3c_drained", host.level, 0);

        // Fill past full, clear the flag, push into a full buffer with a pop, then drain.
        for (int i = 0; i < 9; i++) begin
            vecs[i] = '{rx_valid: 1'b1, rx_data: 8'(i), ready: 1'b0, clear_err: 1'b0,
                        exp_level: (i < 8) ? 4'(i + 1) : 4'd8, exp_valid: 1'b1,
                        exp_overflow: (i == 8)};
        end
        vecs[9]  = '{rx_valid: 1'b0, rx_data: 8'h00, ready: 1'b0, clear_err: 1'b1,
                     exp_level: 4'd8, exp_valid: 1'b1, exp_overflow: 1'b0};
        vecs[10] = '{rx_valid: 1'b1, rx_data: 8'h55, ready: 1'b1, clear_err: 1'b0,
                     exp_level: 4'd8, exp_valid: 1'b1, exp_overflow: 1'b0};
        for (int i = 11; i < 19; i++) begin
            vecs[i] = '{rx_valid: 1'b0, rx_data: 8'h00, ready: 1'b1, clear_err: 1'b0,
                        exp_level: 4'(7 - (i - 11)), exp_valid: ((i - 11) < 7),
                        exp_overflow: 1'b0};
        end

        model_level = 0;
        for (int i = 0; i < 19; i++) begin
            rx_valid   = vecs[i].rx_valid;
            rx_data    = vecs[i].rx_data;
            host.ready = vecs[i].ready;
            clear_err  = vecs[i].clear_err;
            pop = vecs[i].ready && (model_level > 0);
            if (vecs[i].rx_valid && (model_level < DEPTH || pop)) begin
                exp_q.push_back(vecs[i].rx_data);
                model_level++;
            end
            if (pop) model_level--;
            step();
            check($sformatf("vec%0d_level", i), host.level, vecs[i].exp_level);
            check($sformatf("vec%0d_valid", i), host.valid, vecs[i].exp_valid);
            check($sformatf("vec%0d_overflow", i), overflow, vecs[i].exp_overflow);
        end
        rx_valid   = 1'b0;
        clear_err  = 1'b0;
        host.ready = 1'b0;
        repeat (20) step();

        // Disable while ACTIVE with three bytes queued: no idle pulse, bytes still drain.
        for (int i = 0; i < 3; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'h11 * 8'(i + 1);
            exp_q.push_back(rx_data);
            step();
        end
        rx_valid = 1'b0;
        check("dis_pre_state", dut.state, ACTIVE);
        enable = 1'b0;
        step();
        check("dis_rx_en", rx_en, 0);
        check("dis_state", dut.state, OFF);
        idle_seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (idle) idle_seen++;
            step();
        end
        check("dis_no_idle", idle_seen, 0);
        check("dis_level_kept", host.level, 3);
        host.ready = 1'b1;
        repeat (4) step();
        check("dis_drain_level", host.level, 0);
        check("dis_drain_valid", host.valid, 0);
        host.ready = 1'b0;

        // Reset with five bytes queued in ACTIVE discards everything.
        enable = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'hC0 + 8'(i);
            step();
        end
        rx_valid = 1'b0;
        check("rst5_pre_level", host.level, 5);
        check("rst5_pre_state", dut.state, ACTIVE);
        rst = 1'b1;
        step();
        check("rst5_valid", host.valid, 0);
        check("rst5_level", host.level, 0);
        check("rst5_rx_en", rx_en, 0);
        check("rst5_state", dut.state, OFF);
        check("rst5_overflow", overflow, 0);
        rst = 1'b0;
        step();

        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
